// File: rtl/core_sequencer_pkg.sv
// Shared constants and types for core_sequencer: subop codes, control-word
// match pattern and FSM states.
package core_sequencer_pkg;

  localparam logic [1:0] SEQ_END      = 2'b00;
  localparam logic [1:0] SEQ_LOOP_SET = 2'b01;
  localparam logic [1:0] SEQ_JUMP_NZ  = 2'b10;
  localparam logic [1:0] SEQ_WAIT     = 2'b11;

  // Control word: [15:14]=11, [7]=0, [6:5]=11, [4]=0
  localparam logic [15:0] CTRL_MASK = 16'hC0F0;
  localparam logic [15:0] CTRL_VAL  = 16'hC060;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } seq_state_e;

  function automatic logic is_ctrl(input logic [15:0] w);
    return (w & CTRL_MASK) == CTRL_VAL;
  endfunction

endpackage

// File: rtl/core_sequencer_prog_mem.sv
// Program store for core_sequencer: PROG_DEPTH x 16, synchronous write,
// combinational read. Contents are not reset.
module core_sequencer_prog_mem #(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(PROG_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [15:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [15:0]           rdata
);

  logic [15:0] mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/core_sequencer.sv
// Program sequencer: streams a stored shader program as opcode/execute,
// consuming END/LOOP_SET/JUMP_NZ/WAIT locally. Loop support: CORE_SEQUENCER_LOOP_EN.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int PROG_DEPTH = 32,
  localparam int ADDR_WIDTH = $clog2(PROG_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [15:0]           prog_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           opcode,
  output logic                  execute
);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [5:0]            wait_cnt_q, wait_cnt_d;
  logic [15:0]           opcode_q, opcode_d;
  logic                  execute_q, execute_d;
  logic                  done_q, done_d;
`ifdef CORE_SEQUENCER_LOOP_EN
  logic [5:0]            loop_cnt_q, loop_cnt_d;
`endif

  logic [15:0]           word;
  logic [1:0]            subop;
  logic [5:0]            arg;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  mem_we;

  // Writes only land while idle, so a running program never sees them.
  assign mem_we = prog_we && (state_q == IDLE);

  core_sequencer_prog_mem #(
    .PROG_DEPTH (PROG_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (word)
  );

  assign subop  = word[3:2];
  assign arg    = word[13:8];
  assign pc_inc = pc_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_cnt_d = wait_cnt_q;
    opcode_d   = opcode_q;
    execute_d  = 1'b0;
    done_d     = 1'b0;
`ifdef CORE_SEQUENCER_LOOP_EN
    loop_cnt_d = loop_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (!is_ctrl(word)) begin
          opcode_d  = word;
          execute_d = 1'b1;
          pc_d      = pc_inc;
        end else begin
          case (subop)
            SEQ_END: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
            SEQ_LOOP_SET: begin
`ifdef CORE_SEQUENCER_LOOP_EN
              loop_cnt_d = arg;
`endif
              pc_d = pc_inc;
            end
            SEQ_JUMP_NZ: begin
`ifdef CORE_SEQUENCER_LOOP_EN
              if (loop_cnt_q != 6'd0) begin
                loop_cnt_d = loop_cnt_q - 6'd1;
                pc_d       = arg[ADDR_WIDTH-1:0];
              end else begin
                pc_d = pc_inc;
              end
`else
              pc_d = pc_inc;
`endif
            end
            default: begin
              // pc advances now; WAIT just holds it until the count expires
              pc_d = pc_inc;
              if (arg != 6'd0) begin
                wait_cnt_d = arg - 6'd1;
                state_d    = WAIT;
              end
            end
          endcase
        end
      end
      WAIT: begin
        if (wait_cnt_q == 6'd0) state_d = RUN;
        else                    wait_cnt_d = wait_cnt_q - 6'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      wait_cnt_q <= '0;
      opcode_q   <= '0;
      execute_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_cnt_q <= wait_cnt_d;
      opcode_q   <= opcode_d;
      execute_q  <= execute_d;
      done_q     <= done_d;
    end
  end

`ifdef CORE_SEQUENCER_LOOP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) loop_cnt_q <= '0;
    else       loop_cnt_q <= loop_cnt_d;
  end
`endif

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign opcode  = opcode_q;
  assign execute = execute_q;

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Program sequencer on the issuing end of the core array's opcode/execute interface. Holds a small shader program loaded over a write port. Runs it on `start`, streaming one 16-bit opcode per cycle with `execute` asserted. Sequencer-control words (END, LOOP_SET, JUMP_NZ, WAIT) are consumed locally and never forwarded.

## Interface
- `PROG_DEPTH`, 32, program words; power of two, max 64.
- `ADDR_WIDTH`, $clog2(PROG_DEPTH), program counter width (derived).
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state except program memory.
- `prog_we` in 1: program write strobe; honoured only in IDLE.
- `prog_addr` in ADDR_WIDTH: program write address.
- `prog_data` in 16: program write word.
- `start` in 1: run request; honoured only in IDLE.
- `busy` out 1: high from the edge accepting `start` until the edge that processes END.
- `done` out 1: one-cycle pulse on the edge that processes END.
- `opcode` out 16: registered opcode to core array.
- `execute` out 1: registered; high only for forwarded (non-control) words.

## Operation
- Control word: `[15:14]=11`, `[7]=0`, `[6:5]=11`, `[4]=0`. The subop is in `[3:2]` and the argument `arg=[13:8]`. Every other word is forwarded unchanged.
- Subop 00 END: no forward; state goes to IDLE; `done` pulses.
- Subop 01 LOOP_SET: `loop_cnt<=arg`; pc+1.
- Subop 10 JUMP_NZ:
  - If `loop_cnt!=0`: `loop_cnt` decrements and `pc<=arg[ADDR_WIDTH-1:0]`.
  - Otherwise pc+1.
  - With LOOP_SET N, the body runs N+1 times.
- Subop 11 WAIT: no forward; enters WAIT for `arg` extra idle cycles, then resumes at pc+1.
- Loop nesting: single level, one 6-bit `loop_cnt`. A LOOP_SET inside a loop overwrites the counter.
- FSM states:
  - IDLE: `start` moves to RUN with `pc<=0`.
  - RUN: fetch `mem[pc]` and decode.
    - Forwarded word: `opcode<=word`, `execute<=1`, pc+1.
    - Control word: `execute<=0`, and `opcode` holds its previous value.
    - WAIT subop with `arg!=0`: `wait_cnt<=arg-1` and move to WAIT.
  - WAIT: `execute=0`. Decrement `wait_cnt`; when it is 0, return to RUN at the saved pc+1.
- PC wrap: incrementing from PROG_DEPTH-1 wraps to 0. A program with no END runs forever.
- JUMP_NZ argument: target bits above ADDR_WIDTH are ignored.
- Writes: `prog_we` outside IDLE is dropped. `start` while busy is dropped.
- Simultaneous `prog_we` and `start` in IDLE: the write lands first, and the first fetch (next edge) sees the new data.

## Timing
- Reset values: `opcode=0`, `execute=0`, `busy=0`, `done=0`, state IDLE, `pc=0`, `loop_cnt=0`, `wait_cnt=0`. Program memory is not reset.
- Edge T samples `start`; `busy=1` after T. Word 0 appears on `opcode`/`execute` after edge T+1.
- Throughput: one forwarded word per cycle.
- Each control word costs exactly one bubble cycle (`execute=0`). WAIT n costs 1+n bubble cycles.
- END at edge E: `busy=0` and `done=1` after E; `done=0` after E+1. A new `start` is accepted at E+1.
- Reset asserted mid-run forces all outputs to reset values immediately, with no `done` pulse.
- The program memory write port is synchronous; its read is combinational from `pc`, and the result is registered into `opcode`.

## Configuration
- `CORE_SEQUENCER_LOOP_EN` defined: LOOP_SET/JUMP_NZ behave as above.
- Undefined: `loop_cnt` is not built, and both subops decode as one-cycle bubbles advancing pc+1. END and WAIT are unaffected.

## Structure
- Package `core_sequencer_pkg` contains:
  - subop constants `SEQ_END`, `SEQ_LOOP_SET`, `SEQ_JUMP_NZ`, `SEQ_WAIT`;
  - control-word match mask/value constants;
  - FSM state enum `IDLE`/`RUN`/`WAIT`.
- Sub-module `core_sequencer_prog_mem`: PROG_DEPTH x 16 array, synchronous write, combinational read.

## Test plan
- Straight run: program `0x0010,0x0020,0x0030,END`, pulse `start` → `execute` high 3 consecutive cycles starting at T+2 with those opcodes. `done` pulses after the edge that processes END, and `busy` falls the same edge.
- Loop: `LOOP_SET 2`, `0x0041`, `JUMP_NZ 1`, END → `0x0041` issued 3 times, each followed by a 1-cycle bubble. The LOOP_SET adds 1 leading bubble.
- WAIT: `0x0001`, `WAIT 3`, `0x0002`, END → exactly 4 cycles with `execute=0` between the two issues.
- Guards: `prog_we` to addr 0 and a second `start` while busy → memory unchanged and run unaffected. After done, rerun shows the original word 0.
- Reset mid-run: assert `reset` during a loop → `execute`/`busy`/`done` go to 0 asynchronously. After release, `start` runs from pc 0 with `loop_cnt=0`.
- Wrap: PROG_DEPTH=32, no END, word 31=`0x00AA`, word 0=`0x00BB` → `0x00AA` followed directly by `0x00BB`.
- Macro off: same loop program as above → `0x0041` issued once; `done` after 5 cycles of activity.
